// File: rtl/io_port_ctrl.sv
// Buffered CPU I/O port: TX FIFO draining to a valid/ready consumer, 1-deep RX holding
// register, and a status register with a sticky overflow flag.
module io_port_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  OUT_ADDR  = 8'h00,
  parameter logic [7:0]  IN_ADDR   = 8'h01,
  parameter logic [7:0]  STAT_ADDR = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_io,
  input  logic       c_ri,
  input  logic       c_ro,
  input  logic [7:0] addr_bus,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rd_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    rx_reg;
  logic          rx_full;
  logic          ovf;

  // Write-edge regs hold "strobe was low last edge"; resetting them to 0 means a
  // strobe still held across reset release is never taken as a fresh write.
  logic          out_wr_armed_q;
  logic          stat_wr_armed_q;
  logic          in_rd_q;

  logic out_wr_hit, stat_wr_hit, in_rd_hit, stat_rd_hit;
  logic out_wr_edge, stat_wr_edge, in_rd_fall;
  logic fifo_empty, fifo_full;
  logic tx_pop, tx_push, ovf_set;
  logic rx_pop, rx_cap;

  // Address decode and transfer qualification
  always_comb begin
    out_wr_hit   = mem_io & c_ri & (addr_bus == OUT_ADDR);
    stat_wr_hit  = mem_io & c_ri & (addr_bus == STAT_ADDR);
    in_rd_hit    = mem_io & c_ro & (addr_bus == IN_ADDR);
    stat_rd_hit  = mem_io & c_ro & (addr_bus == STAT_ADDR);
    out_wr_edge  = out_wr_hit & out_wr_armed_q;
    stat_wr_edge = stat_wr_hit & stat_wr_armed_q;
    in_rd_fall   = in_rd_q & ~in_rd_hit;
    fifo_empty   = (count == '0);
    fifo_full    = (count == FULL_CNT);
    tx_pop       = ~fifo_empty & tx_ready;
    tx_push      = out_wr_edge & (~fifo_full | tx_pop);
    ovf_set      = out_wr_edge & fifo_full & ~tx_pop;
    rx_pop       = in_rd_fall & rx_full;
    rx_cap       = rx_valid & ~rx_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rx_reg          <= '0;
      rx_full         <= 1'b0;
      ovf             <= 1'b0;
      out_wr_armed_q  <= 1'b0;
      stat_wr_armed_q <= 1'b0;
      in_rd_q         <= 1'b0;
    end else begin
      out_wr_armed_q  <= ~out_wr_hit;
      stat_wr_armed_q <= ~stat_wr_hit;
      in_rd_q         <= in_rd_hit;
      if (tx_push) wr_ptr <= wr_ptr + PW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(tx_push) - CW'(tx_pop);
      if (stat_wr_edge)  ovf <= 1'b0;
      else if (ovf_set)  ovf <= 1'b1;
      // A pending RX pop always beats a capture; rx_ready is low then anyway
      if (rx_pop) begin
        rx_full <= 1'b0;
      end else if (rx_cap) begin
        rx_full <= 1'b1;
        rx_reg  <= rx_data;
      end
    end
  end

  // FIFO storage needs no reset: tx_data is masked while empty
  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= wdata;
  end

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign rx_ready = ~rx_full;

  // CPU read mux; bus released while in reset
  always_comb begin
    rd_oe = 1'b0;
    rdata = 8'h00;
    if (!reset) begin
      if (in_rd_hit) begin
        rd_oe = 1'b1;
        rdata = rx_full ? rx_reg : 8'hFF;
      end else if (stat_rd_hit) begin
        rd_oe = 1'b1;
        rdata = {4'b0000, ovf, rx_full, fifo_empty, fifo_full};
      end
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus randomized bus/stream traffic,
// every cycle compared against a queue-based reference model.
module tb_io_port_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_io, c_ri, c_ro;
  logic [7:0] addr_bus, wdata;
  logic [7:0] rdata;
  logic       rd_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks = 0;
  int errors = 0;

  io_port_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_io(mem_io), .c_ri(c_ri), .c_ro(c_ro),
    .addr_bus(addr_bus), .wdata(wdata), .rdata(rdata), .rd_oe(rd_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_rx_full;
  logic [7:0] m_rx;
  bit         p_out, p_stat, p_in;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_rx_full = 0; m_rx = 8'h00;
    p_out = 1; p_stat = 1; p_in = 0;  // held strobes after reset are not new edges
  endfunction

  function automatic void model_update();
    bit ow, sw, ir;
    ow = mem_io && c_ri && addr_bus == 8'h00;
    sw = mem_io && c_ri && addr_bus == 8'h02;
    ir = mem_io && c_ro && addr_bus == 8'h01;
    if (q.size() != 0 && tx_ready) void'(q.pop_front());
    if (ow && !p_out) begin
      if (q.size() < DEPTH) q.push_back(wdata);
      else m_ovf = 1;
    end
    if (sw && !p_stat) m_ovf = 0;
    if (p_in && !ir && m_rx_full) m_rx_full = 0;
    else if (rx_valid && !m_rx_full) begin
      m_rx_full = 1;
      m_rx = rx_data;
    end
    p_out = ow; p_stat = sw; p_in = ir;
  endfunction

  function automatic logic [8:0] model_read();
    if (reset || !mem_io || !c_ro) return 9'h000;
    if (addr_bus == 8'h01) return {1'b1, m_rx_full ? m_rx : 8'hFF};
    if (addr_bus == 8'h02)
      return {1'b1, 4'b0000, m_ovf, m_rx_full, q.size() == 0, q.size() == DEPTH};
    return 9'h000;
  endfunction

  // One cycle: inputs already set after a negedge; compare, clock, advance model
  task automatic step();
    logic [8:0] rd;
    if (reset) model_reset();
    #1;
    rd = model_read();
    chk("tx_valid", 8'(tx_valid), 8'(q.size() != 0));
    chk("tx_data", tx_data, (q.size() != 0) ? q[0] : 8'h00);
    chk("rx_ready", 8'(rx_ready), 8'(!m_rx_full));
    chk("rd_oe", 8'(rd_oe), 8'(rd[8]));
    chk("rdata", rdata, rd[7:0]);
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    @(negedge clk);
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d, input int hold);
    mem_io = 1; c_ri = 1; addr_bus = a; wdata = d;
    repeat (hold) step();
    c_ri = 0;
    step();
  endtask

  task automatic io_rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    mem_io = 1; c_ro = 1; addr_bus = a;
    #1 chk(tag, rdata, exp);
    step();
    c_ro = 0;
    step();
  endtask

  task automatic drain(input logic [7:0] exp[$], input string tag);
    tx_ready = 1;
    foreach (exp[i]) begin
      #1 chk(tag, tx_data, exp[i]);
      step();
    end
    #1 chk({tag, "_empty"}, 8'(tx_valid), 8'h00);
    tx_ready = 0;
  endtask

  initial begin
    logic [7:0] e[$];
    reset = 1; mem_io = 0; c_ri = 0; c_ro = 0; addr_bus = 0; wdata = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    model_reset();
    @(negedge clk);
    step(); step();
    reset = 0;
    step();
    #1 chk("idle_tx_valid", 8'(tx_valid), 8'h00);
    chk("idle_rx_ready", 8'(rx_ready), 8'h01);
    chk("idle_rd_oe", 8'(rd_oe), 8'h00);
    io_rd(8'h02, 8'h02, "stat_reset");

    // Ordered drain of three queued bytes
    io_wr(8'h00, 8'h11, 1); io_wr(8'h00, 8'h22, 1); io_wr(8'h00, 8'h33, 1);
    e = '{8'h11, 8'h22, 8'h33};
    drain(e, "drain3");

    // Long strobe yields a single entry
    io_wr(8'h00, 8'h44, 5);
    io_rd(8'h02, 8'h00, "stat_one");
    e = '{8'h44};
    drain(e, "hold5");

    // Overflow and sticky clear
    for (int k = 0; k < 5; k++) io_wr(8'h00, 8'hA0 + 8'(k), 1);
    io_rd(8'h02, 8'h09, "stat_ovf");
    io_wr(8'h02, 8'hFF, 1);
    io_rd(8'h02, 8'h01, "stat_ovf_clr");

    // Full FIFO: push and pop on the same edge
    mem_io = 1; c_ri = 1; addr_bus = 8'h00; wdata = 8'hB0; tx_ready = 1;
    #1 chk("full_pp_head", tx_data, 8'hA0);
    step();
    c_ri = 0; tx_ready = 0;
    step();
    io_rd(8'h02, 8'h01, "stat_full_pp");
    e = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    drain(e, "full_pp");

    // RX capture and read-clear on strobe fall
    rx_data = 8'hA5; rx_valid = 1;
    step();
    rx_valid = 0; rx_data = 8'h00;
    #1 chk("rx_full_ready", 8'(rx_ready), 8'h00);
    io_rd(8'h02, 8'h06, "stat_rx");
    io_rd(8'h01, 8'hA5, "rx_read");
    #1 chk("rx_released", 8'(rx_ready), 8'h01);
    io_rd(8'h01, 8'hFF, "rx_empty_read");

    // Reset with bytes queued
    io_wr(8'h00, 8'h01, 1); io_wr(8'h00, 8'h02, 1); io_wr(8'h00, 8'h03, 1);
    reset = 1;
    #1 chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    step();
    reset = 0; tx_ready = 1;
    repeat (3) begin
      #1 chk("post_rst_tx", 8'(tx_valid), 8'h00);
      step();
    end
    tx_ready = 0;

    // Write strobe held across reset is not a new write
    mem_io = 1; c_ri = 1; addr_bus = 8'h00; wdata = 8'h77;
    step();
    reset = 1;
    step();
    reset = 0;
    step(); step();
    #1 chk("held_strobe", 8'(tx_valid), 8'h00);
    c_ri = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_io   = ($urandom_range(0, 7) != 0);
        addr_bus = 8'($urandom_range(0, 3));
        wdata    = 8'($urandom);
        case ($urandom_range(0, 2))
          0: begin c_ri = 0; c_ro = 0; end
          1: begin c_ri = 1; c_ro = 0; end
          default: begin c_ri = 0; c_ro = 1; end
        endcase
      end
      tx_ready = ((i % 1000) < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 400) == 0);
      step();
    end
    reset = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
